// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one WIDTH-bit adder shared round-robin between NUM_REQ
// requesters. The winning operands are summed and captured together with the
// winner's index in a single-entry output register that has valid/ready
// backpressure.
module add_share_arbiter #(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_sum,
  output logic [ID_WIDTH-1:0]        out_id
);

  // Output-stage occupancy; FULL is exactly "out_valid is high".
  localparam logic STATE_EMPTY = 1'b0;
  localparam logic STATE_FULL  = 1'b1;

  logic                state_q, state_d;
  logic [WIDTH-1:0]    out_sum_q, out_sum_d;
  logic [ID_WIDTH-1:0] out_id_q, out_id_d;
  logic [ID_WIDTH-1:0] last_grant_q, last_grant_d;

  logic                acc_en;
  logic                transfer;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                grant_found;
  int                  scan_idx;
  logic [ID_WIDTH-1:0] scan_sel;

  logic [WIDTH-1:0]    a_arr [NUM_REQ];
  logic [WIDTH-1:0]    b_arr [NUM_REQ];
  logic [WIDTH-1:0]    a_sel;
  logic [WIDTH-1:0]    b_sel;
  logic [WIDTH-1:0]    sum_val;

  // Unpack the flat operand buses into per-requester lanes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
    assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
  end

  // The output register can take a new result when it is empty or being
  // drained this cycle. Held low in reset so no requester sees a handshake
  // that the register would not capture.
  assign acc_en   = resetn & ((state_q == STATE_EMPTY) | out_ready);
  assign transfer = grant_found & acc_en;

  // Round-robin pick: scan from the requester after the last winner, wrapping.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    scan_sel    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(last_grant_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_sel = ID_WIDTH'(scan_idx);
      if (!grant_found && req_valid[scan_sel]) begin
        grant[scan_sel] = 1'b1;
        grant_id        = scan_sel;
        grant_found     = 1'b1;
      end
    end
  end

  // The single shared adder, fed from the winner's lane; carry-out dropped.
  always_comb begin
    a_sel   = a_arr[grant_id];
    b_sel   = b_arr[grant_id];
    sum_val = a_sel + b_sel;
  end

  // Next-state for the output stage and the priority pointer.
  always_comb begin
    state_d      = state_q;
    out_sum_d    = out_sum_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    if (transfer) begin
      state_d      = STATE_FULL;
      out_sum_d    = sum_val;
      out_id_d     = grant_id;
      last_grant_d = grant_id;
    end else if ((state_q == STATE_FULL) && out_ready) begin
      state_d = STATE_EMPTY;
    end
  end

  // State registers; reset points the pointer at the last requester so
  // requester 0 wins first.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= STATE_EMPTY;
      out_sum_q    <= '0;
      out_id_q     <= '0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      out_sum_q    <= out_sum_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready = grant & {NUM_REQ{acc_en}};
  assign out_valid = (state_q == STATE_FULL);
  assign out_sum   = out_sum_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_add_share_arbiter.sv
// Bench for add_share_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-free
// behavioural model of the arbiter and its output register.
module tb_add_share_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;

  logic                     clock;
  logic                     resetn;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_sum;
  logic [1:0]               out_id;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int m_valid;
  int m_sum;
  int m_id;
  int m_last;

  add_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_id    (out_id)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!resetn) begin
        m_valid = 0;
        m_sum   = 0;
        m_id    = 0;
        m_last  = NUM_REQ - 1;
        check("m_rst_valid", 32'(out_valid), 32'(0));
        check("m_rst_sum",   32'(out_sum),   32'(0));
        check("m_rst_id",    32'(out_id),    32'(0));
        check("m_rst_ready", 32'(req_ready), 32'(0));
      end else begin
        int best;
        int bestd;
        int d;
        logic [NUM_REQ-1:0] exp_ready;
        check("m_valid", 32'(out_valid), 32'(m_valid));
        check("m_sum",   32'(out_sum),   32'(m_sum));
        check("m_id",    32'(out_id),    32'(m_id));
        // Winner = valid requester closest after the last winner (cyclic).
        best  = -1;
        bestd = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req_valid[i]) begin
            d = (i - m_last - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
        exp_ready = '0;
        if (best >= 0 && (m_valid == 0 || out_ready)) begin
          exp_ready[best] = 1'b1;
        end
        check("m_ready", 32'(req_ready), 32'(exp_ready));
        if (exp_ready != '0) begin
          m_sum   = (int'(req_a[best*WIDTH +: WIDTH]) + int'(req_b[best*WIDTH +: WIDTH])) % 256;
          m_id    = best;
          m_last  = best;
          m_valid = 1;
        end else if (out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  // Directed scenarios followed by random traffic.
  initial begin
    resetn    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b0;

    // Reset state, even with requests pending
    #2;
    req_valid = 4'hF;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_sum",   32'(out_sum),   32'(0));
    check("rst_out_id",    32'(out_id),    32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    req_valid = '0;
    tick();
    tick();
    resetn = 1'b1;

    // Round-robin streaming with a=i, b=10
    for (int i = 0; i < NUM_REQ; i++) set_op(i, 8'(i), 8'd10);
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("stream_valid", 32'(out_valid), 32'(1));
      check("stream_id",    32'(out_id),    32'(k % 4));
      check("stream_sum",   32'(out_sum),   32'(10 + k % 4));
      if (k < 4) tick();
    end
    req_valid = '0;
    tick();
    check("drain_empty", 32'(out_valid), 32'(0));

    // Wrap-around sum
    set_op(2, 8'hF0, 8'h20);
    req_valid = 4'b0100;
    #1;
    check("wrap_ready", 32'(req_ready), 32'h4);
    tick();
    check("wrap_valid", 32'(out_valid), 32'(1));
    check("wrap_sum",   32'(out_sum),   32'h10);
    check("wrap_id",    32'(out_id),    32'(2));
    req_valid = '0;
    tick();

    // Priority skip after a grant to 1, with idle cycles in between
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    check("skip_ready3", 32'(req_ready), 32'h8);
    tick();
    check("skip_id3",    32'(out_id),    32'(3));
    check("skip_ready0", 32'(req_ready), 32'h1);
    tick();
    check("skip_id0",    32'(out_id),    32'(0));
    req_valid = '0;
    tick();

    // Backpressure: hold 0x2A from requester 1
    set_op(1, 8'h20, 8'h0A);
    req_valid = 4'b0010;
    out_ready = 1'b0;
    tick();
    req_valid = 4'hF;
    set_op(0, 8'($urandom), 8'($urandom));
    set_op(1, 8'($urandom), 8'($urandom));
    set_op(2, 8'h05, 8'h06);
    set_op(3, 8'($urandom), 8'($urandom));
    for (int k = 0; k < 3; k++) begin
      check("bp_ready", 32'(req_ready), 32'(0));
      check("bp_sum",   32'(out_sum),   32'h2A);
      check("bp_id",    32'(out_id),    32'(1));
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    check("bp_next_id",  32'(out_id),  32'(2));
    check("bp_next_sum", 32'(out_sum), 32'h0B);

    // Async reset while holding a result
    out_ready = 1'b0;
    tick();
    check("hold_valid", 32'(out_valid), 32'(1));
    #2;
    resetn = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'(0));
    check("arst_sum",   32'(out_sum),   32'(0));
    check("arst_id",    32'(out_id),    32'(0));
    tick();
    resetn    = 1'b1;
    out_ready = 1'b1;
    req_valid = 4'hF;
    #1;
    check("arst_regrant", 32'(req_ready), 32'h1);
    tick();
    check("arst_id0", 32'(out_id), 32'(0));

    // Randomized traffic with occasional reset pulses
    for (int c = 0; c < 3000; c++) begin
      req_valid = 4'($urandom);
      req_a     = 32'($urandom);
      req_b     = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      resetn    = ($urandom_range(0, 199) != 0);
      tick();
    end
    resetn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one WIDTH-bit integer adder between NUM_REQ requesters (e.g. accumulator lanes or exponent-adjust units) so a single adder instance serves all of them.
- Arbitrates round-robin and adds the winning operands.
- Registers the sum with the winner's ID into a one-entry output stage with valid/ready backpressure.
- Sits between requester lanes and a shared result return path.

Parameters:
- WIDTH, 8, operand/sum width in bits.
- NUM_REQ, 4, number of requesters (>=2).
- ID_WIDTH, $clog2(NUM_REQ), requester ID width. Derived; not overridden.

Ports:
- clock  input  1  single clock.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a  input  NUM_REQ*WIDTH  packed operand A; requester i at bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  packed operand B, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  registered sum.
- out_id  output  ID_WIDTH  index of the requester that produced out_sum.

Behaviour:
- Reset (resetn low, async): out_valid=0, out_sum=0, out_id=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset. Any pending result is discarded.
- State machine, two states:
  - EMPTY: output register free. out_valid=0.
  - FULL: result held. out_valid=1.
- Accept enable (combinational): acc_en = !out_valid | out_ready.
- Grant (combinational): grant is one-hot. It picks the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap. grant is 0 if no req_valid bit is set.
- req_ready = grant & {NUM_REQ{acc_en}}.
  - req_ready may depend combinationally on req_valid and out_ready.
  - req_ready never depends on operand values.
- Transfer on requester i when req_valid[i] & req_ready[i]. On that clock edge:
  - out_sum <= (req_a_i + req_b_i) mod 2^WIDTH. Carry-out is dropped; no saturation.
  - out_id <= i.
  - out_valid <= 1.
  - last_grant <= i.
- Transitions:
  - EMPTY -> FULL on transfer.
  - FULL -> FULL when out_ready & transfer in the same cycle. This is the simultaneous drain and refill case; the new result replaces the old with no bubble.
  - FULL -> EMPTY when out_ready & no transfer.
  - FULL & !out_ready: hold. out_sum and out_id stay stable; all req_ready=0.
- Latency: 1 cycle from transfer to out_valid.
- Throughput: 1 result per cycle while out_ready=1.
- Fairness: a requester holding req_valid is granted within NUM_REQ transfers.
- last_grant updates only on a transfer. Idle cycles do not rotate priority.
- Requester rules:
  - A requester may drop req_valid before being granted; the arbiter re-grants freely.
  - Operands are sampled only in the transfer cycle.
- No request pending while FULL and out_ready=1: drain to EMPTY.
- out_* values while out_valid=0 are don't-care for consumers, but are held at their last value. They are 0 after reset.

Test Plan:
- Reset then idle: resetn=0 -> out_valid=0, out_sum=0, out_id=0, req_ready=0. After release, all req_valid=1 with out_ready=1 -> first grant is requester 0.
- Wrap-around sum: only req 2 valid, a=8'hF0, b=8'h20 -> req_ready=4'b0100 that cycle. Next cycle out_valid=1, out_sum=8'h10, out_id=2.
- Round-robin streaming:
  - Stimulus: all 4 req_valid held, out_ready=1, operands a=i, b=10.
  - Required: out_id sequence 0,1,2,3,0 on consecutive cycles and out_sum=10,11,12,13,10, with no bubbles.
- Priority skip: after a grant to 1, only reqs 0 and 3 valid -> grants go 3 then 0. Idle cycles in between do not change this order.
- Backpressure:
  - Stimulus: result 8'h2A held with out_ready=0 for 3 cycles while reqs are pending.
  - Required: req_ready=0 throughout; out_sum=8'h2A and out_id stable.
  - Then raise out_ready -> the same cycle shows a grant, and the next result appears the next cycle.
- Async reset mid-hold: out_valid=1 with out_ready=0, then assert resetn=0 between edges.
  - Required: out_valid drops to 0 immediately and the result is lost.
  - After release with all reqs valid -> grant to 0.
